// File: rtl/motoro3_pwm_gen_multi_if.sv
// Bundle between the commutation sequencer and the PWM generator.
// master = sequencer side (drives enables/config), slave = PWM generator.
interface motoro3_pwm_gen_multi_if #(
  parameter int CNT_W = 13
);
  logic             aE;
  logic             bE;
  logic             cE;
  logic             m3cntLast1;
  logic             cfgWr;
  logic [CNT_W-1:0] dutyIn;
  logic [CNT_W-1:0] periodIn;
  logic             pwm;
  logic             periodEnd;
  logic             dutyClamped;

  modport master (
    output aE, bE, cE, m3cntLast1, cfgWr, dutyIn, periodIn,
    input  pwm, periodEnd, dutyClamped
  );

  modport slave (
    input  aE, bE, cE, m3cntLast1, cfgWr, dutyIn, periodIn,
    output pwm, periodEnd, dutyClamped
  );
endinterface

// File: rtl/motoro3_pwm_gen_multi.sv
// Double-buffered PWM generator with min on/off pulse suppression; pwm is registered (1 clk after load).
// Optional soft-start ramp on duty increases: define MOTORO3_PWM_SOFTSTART_EN.
module motoro3_pwm_gen_multi #(
  parameter int CNT_W     = 13,
  parameter int MIN_ON    = 32,
  parameter int MIN_OFF   = 32,
  parameter int RAMP_STEP = 4
) (
  input  logic                       clk,
  input  logic                       nRst,
  motoro3_pwm_gen_multi_if.slave     bus
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t MIN_ON_C  = cnt_t'(MIN_ON);
  localparam cnt_t MIN_OFF_C = cnt_t'(MIN_OFF);
  localparam cnt_t ONE       = cnt_t'(1);
  localparam cnt_t TWO       = cnt_t'(2);

  if (CNT_W < 2 || MIN_ON < 1 || MIN_OFF < 0 || RAMP_STEP < 1) begin : g_param_chk
    $error("motoro3_pwm_gen_multi: illegal parameter set");
  end

  // A zero duty is caught by the MIN_ON test, since MIN_ON >= 1.
  function automatic cnt_t clamp_duty(input cnt_t d, input cnt_t p);
    cnt_t r;
    r = d;
    if (d < MIN_ON_C)
      r = '0;
    else if ((d < p) && ((p - d) < MIN_OFF_C))
      r = p;
    return r;
  endfunction

  cnt_t cnt, p_act, d_act, sh_d, sh_p;
  logic idle_q, pwm_q, pe_q, clamped_q;

  logic idle, last, load;
  cnt_t per_in, duty_in, tgt, d_new, p_nxt, d_nxt, cnt_nxt;
  logic pwm_nxt, pe_nxt;

`ifdef MOTORO3_PWM_SOFTSTART_EN
  localparam cnt_t RAMP_C = cnt_t'(RAMP_STEP);
  cnt_t ramp;
`endif

  always_comb begin
    per_in  = (bus.periodIn < TWO) ? TWO : bus.periodIn;
    duty_in = (bus.dutyIn > per_in) ? per_in : bus.dutyIn;

    idle = !(bus.aE || bus.bE || bus.cE);
    last = (cnt == p_act - ONE);
    load = idle || last || bus.m3cntLast1;

`ifdef MOTORO3_PWM_SOFTSTART_EN
    // Ramp base is the pre-clamp target so it can grow through the MIN_ON dead zone.
    if (idle)
      tgt = '0;
    else if ((sh_d > ramp) && ((sh_d - ramp) > RAMP_C))
      tgt = ramp + RAMP_C;
    else
      tgt = sh_d;
`else
    tgt = sh_d;
`endif

    d_new = clamp_duty(tgt, sh_p);
    p_nxt = load ? sh_p  : p_act;
    d_nxt = load ? d_new : d_act;

    // First enabled cycle after idle restarts the period so it runs a full Pact.
    cnt_nxt = (load || idle_q) ? '0 : cnt + ONE;
    pwm_nxt = !idle && (cnt_nxt < d_nxt);
    pe_nxt  = !idle && (cnt_nxt == p_nxt - ONE);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sh_d <= '0;
      sh_p <= '1;
    end else if (bus.cfgWr) begin
      sh_d <= duty_in;
      sh_p <= per_in;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt       <= '0;
      p_act     <= '1;
      d_act     <= '0;
      idle_q    <= 1'b1;
      pwm_q     <= 1'b0;
      pe_q      <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      p_act  <= p_nxt;
      d_act  <= d_nxt;
      idle_q <= idle;
      pwm_q  <= pwm_nxt;
      pe_q   <= pe_nxt;
      if (load)
        clamped_q <= (d_new != tgt);
    end
  end

`ifdef MOTORO3_PWM_SOFTSTART_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      ramp <= '0;
    else if (load)
      ramp <= tgt;
  end
`endif

  assign bus.pwm         = pwm_q;
  assign bus.periodEnd   = pe_q;
  assign bus.dutyClamped = clamped_q;

endmodule

// File: tb/tb_motoro3_pwm_gen_multi.sv
// Directed bench for motoro3_pwm_gen_multi (default build, no soft-start).
// Inputs change and outputs are sampled on the falling edge.
module tb_motoro3_pwm_gen_multi;

  localparam int CNT_W = 13;

  logic clk;
  logic nRst;
  int   n_chk;
  int   n_bad;

  motoro3_pwm_gen_multi_if #(.CNT_W(CNT_W)) bus ();

  motoro3_pwm_gen_multi #(
    .CNT_W(CNT_W), .MIN_ON(32), .MIN_OFF(32), .RAMP_STEP(4)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg(input int d, input int p);
    bus.dutyIn   = CNT_W'(d);
    bus.periodIn = CNT_W'(p);
    bus.cfgWr    = 1'b1;
    tick();
    bus.cfgWr    = 1'b0;
  endtask

  // Samples n consecutive cycles starting with the current one.
  task automatic measure(input int n, output int hi, output int pe, output int pe_idx);
    hi = 0; pe = 0; pe_idx = -1;
    for (int i = 0; i < n; i++) begin
      if (bus.pwm) hi++;
      if (bus.periodEnd) begin
        pe++;
        if (pe_idx < 0) pe_idx = i;
      end
      tick();
    end
  endtask

  int hi, pe, idx;

  initial begin
    n_chk = 0; n_bad = 0;
    nRst = 1'b0;
    bus.aE = 0; bus.bE = 0; bus.cE = 0;
    bus.m3cntLast1 = 0; bus.cfgWr = 0;
    bus.dutyIn = '0; bus.periodIn = '0;
    repeat (3) tick();
    chk("rst_pwm", bus.pwm, 0);
    chk("rst_pe", bus.periodEnd, 0);
    chk("rst_clamp", bus.dutyClamped, 0);
    nRst = 1'b1;
    tick();

    // 100/400 configured while idle, loaded by the idle load, then enable
    cfg(100, 400);
    tick();
    bus.aE = 1'b1;
    tick();
    chk("start_pwm", bus.pwm, 1);
    measure(800, hi, pe, idx);
    chk("d100_hi", hi, 200);
    chk("d100_pe", pe, 2);
    chk("d100_pe_idx", idx, 399);
    chk("d100_clamp", bus.dutyClamped, 0);

    // duty below MIN_ON suppressed; takes effect at next period end
    cfg(10, 400);
    measure(399, hi, pe, idx);
    chk("d10_old_hi", hi, 99);
    chk("d10_old_pe", pe, 1);
    measure(400, hi, pe, idx);
    chk("d10_hi", hi, 0);
    chk("d10_clamp", bus.dutyClamped, 1);

    // off-gap below MIN_OFF forced full-on
    cfg(390, 400);
    measure(399, hi, pe, idx);
    chk("d390_old_hi", hi, 0);
    measure(800, hi, pe, idx);
    chk("d390_hi", hi, 800);
    chk("d390_pe", pe, 2);
    chk("d390_clamp", bus.dutyClamped, 1);

    // mid-period shadow write does not disturb the running period
    cfg(100, 400);
    measure(399, hi, pe, idx);
    chk("back100_old_hi", hi, 399);
    measure(150, hi, pe, idx);
    chk("mid_first_hi", hi, 100);
    cfg(200, 400);
    measure(249, hi, pe, idx);
    chk("mid_rest_hi", hi, 0);
    chk("mid_rest_pe", pe, 1);
    measure(400, hi, pe, idx);
    chk("d200_hi", hi, 200);
    chk("d200_clamp", bus.dutyClamped, 0);

    // commutation restart at cnt=250 loads new shadow, no periodEnd for truncated period
    cfg(300, 400);
    measure(249, hi, pe, idx);
    chk("trunc_hi", hi, 199);
    chk("trunc_pe", pe, 0);
    bus.m3cntLast1 = 1'b1;
    tick();
    bus.m3cntLast1 = 1'b0;
    chk("m3_pwm", bus.pwm, 1);
    chk("m3_pe", bus.periodEnd, 0);
    measure(400, hi, pe, idx);
    chk("d300_hi", hi, 300);
    chk("d300_pe_idx", idx, 399);

    // commutation pulse on the last clock of a period: one load, one pulse
    measure(399, hi, pe, idx);
    chk("coinc_pre_pe", pe, 0);
    chk("coinc_pe_now", bus.periodEnd, 1);
    bus.m3cntLast1 = 1'b1;
    tick();
    bus.m3cntLast1 = 1'b0;
    chk("coinc_pe_after", bus.periodEnd, 0);
    measure(400, hi, pe, idx);
    chk("coinc_next_hi", hi, 300);
    chk("coinc_next_pe", pe, 1);

    // go idle mid-pulse, reconfigure while idle, re-enable on phase B
    measure(50, hi, pe, idx);
    chk("pre_idle_pwm", bus.pwm, 1);
    bus.aE = 1'b0;
    tick();
    chk("idle_pwm", bus.pwm, 0);
    measure(5, hi, pe, idx);
    chk("idle_hi", hi, 0);
    chk("idle_pe", pe, 0);
    cfg(120, 400);
    tick();
    bus.bE = 1'b1;
    tick();
    chk("reen_pwm", bus.pwm, 1);
    measure(400, hi, pe, idx);
    chk("reen_hi", hi, 120);
    chk("reen_pe_idx", idx, 399);

    // dutyIn above periodIn stored as period -> full on, not a min-pulse clamp
    cfg(500, 400);
    measure(399, hi, pe, idx);
    chk("over_old_hi", hi, 119);
    measure(400, hi, pe, idx);
    chk("over_hi", hi, 400);
    chk("over_clamp", bus.dutyClamped, 0);

    // periodIn below 2 stored as 2
    cfg(5, 1);
    measure(399, hi, pe, idx);
    chk("p2_old_hi", hi, 399);
    measure(10, hi, pe, idx);
    chk("p2_pe", pe, 5);
    chk("p2_hi", hi, 0);
    chk("p2_clamp", bus.dutyClamped, 1);

    // MIN_ON / MIN_OFF boundaries
    cfg(32, 400);
    tick();
    measure(400, hi, pe, idx);
    chk("d32_hi", hi, 32);
    chk("d32_clamp", bus.dutyClamped, 0);
    cfg(368, 400);
    measure(399, hi, pe, idx);
    measure(400, hi, pe, idx);
    chk("d368_hi", hi, 368);
    chk("d368_clamp", bus.dutyClamped, 0);
    cfg(369, 400);
    measure(399, hi, pe, idx);
    chk("d369_old_hi", hi, 367);
    measure(400, hi, pe, idx);
    chk("d369_hi", hi, 400);
    chk("d369_clamp", bus.dutyClamped, 1);

    // asynchronous reset mid-period
    measure(20, hi, pe, idx);
    nRst = 1'b0;
    #1;
    chk("arst_pwm", bus.pwm, 0);
    chk("arst_clamp", bus.dutyClamped, 0);
    tick();
    nRst = 1'b1;
    tick();
    chk("arst_pe", bus.periodEnd, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
